// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues credited in-order ICache requests,
// discards responses made stale by a redirect and buffers live instructions for IFID.
module fetch_seq_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] START_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Ctrl_ExcpFlag,
  input  logic [ADDR_WIDTH-1:0] Ctrl_ExcpPC,
  input  logic                  EX_BranchFlag,
  input  logic [ADDR_WIDTH-1:0] EX_BranchPC,
  input  logic                  BP_BranchFlag,
  input  logic [ADDR_WIDTH-1:0] BranchPredictor_PC,
  input  logic                  Stall,
  output logic                  ic_req_valid,
  input  logic                  ic_req_ready,
  output logic [ADDR_WIDTH-1:0] ic_req_addr,
  input  logic                  ic_resp_valid,
  input  logic [INST_WIDTH-1:0] ic_resp_data,
  output logic                  inst_valid,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_EXT = (CW+1)'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] resp_pc;
  logic [ADDR_WIDTH-1:0] target;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         kill_cnt;
  logic [CW-1:0]         fifo_count;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [INST_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem   [FIFO_DEPTH];
  logic [CW:0]           credit_used;
  logic                  redirect;
  logic                  req_fire;
  logic                  resp_take;
  logic                  push;
  logic                  pop;

  assign redirect = Ctrl_ExcpFlag | EX_BranchFlag | BP_BranchFlag;

  always_comb begin
    target = BranchPredictor_PC;
    if (Ctrl_ExcpFlag)
      target = Ctrl_ExcpPC;
    else if (EX_BranchFlag)
      target = EX_BranchPC;
  end

  // Credits cover both in-flight requests and buffered entries, so a push can never overflow.
  assign credit_used  = {1'b0, outstanding} + {1'b0, fifo_count};
  assign ic_req_valid = rst_n & ~redirect & (credit_used < DEPTH_EXT);
  assign ic_req_addr  = fetch_pc;
  assign req_fire     = ic_req_valid & ic_req_ready;

  assign resp_take = ic_resp_valid & (outstanding != '0);
  assign push      = resp_take & ~redirect & (kill_cnt == '0);

  assign inst_valid = (fifo_count != '0);
  assign pop        = inst_valid & ~Stall & ~redirect;
  assign inst       = inst_valid ? data_mem[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? pc_mem[rd_ptr]   : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= START_PC;
      resp_pc  <= START_PC;
    end else if (redirect) begin
      fetch_pc <= target;
      resp_pc  <= target;
    end else begin
      if (req_fire)
        fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
      if (push)
        resp_pc <= resp_pc + ADDR_WIDTH'(4);
    end
  end

  // On redirect every request still in flight becomes stale and must be swallowed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      kill_cnt    <= '0;
    end else if (redirect) begin
      outstanding <= outstanding - CW'(resp_take);
      kill_cnt    <= outstanding - CW'(resp_take);
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(resp_take);
      if (resp_take && (kill_cnt != '0))
        kill_cnt <= kill_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else if (redirect) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= ic_resp_data;
      pc_mem[wr_ptr]   <= resp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Scoreboard bench for fetch_seq_ctrl: an ICache model answers requests one cycle later,
// a monitor compares every cycle against epoch-tagged expectations plus directed checkpoints.
module tb_fetch_seq_ctrl;

  localparam int          DEPTH = 4;
  localparam logic [31:0] START = 32'h8000_0000;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Ctrl_ExcpFlag = 1'b0;
  logic [31:0] Ctrl_ExcpPC = '0;
  logic        EX_BranchFlag = 1'b0;
  logic [31:0] EX_BranchPC = '0;
  logic        BP_BranchFlag = 1'b0;
  logic [31:0] BranchPredictor_PC = '0;
  logic        Stall = 1'b0;
  logic        ic_req_valid;
  logic        ic_req_ready = 1'b0;
  logic [31:0] ic_req_addr;
  logic        ic_resp_valid;
  logic [31:0] ic_resp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  req_t        pend_q[$];
  exp_t        exp_q[$];
  logic [31:0] req_log[$];
  logic [31:0] pop_log[$];
  int          errors = 0;
  int          checks = 0;
  int          epoch = 0;
  logic [31:0] exp_fetch_pc = START;
  logic        resp_en = 1'b0;
  logic        spurious = 1'b0;
  logic        resp_real = 1'b0;
  logic [31:0] resp_addr = '0;
  int          resp_epoch = 0;

  fetch_seq_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .Ctrl_ExcpFlag     (Ctrl_ExcpFlag),
    .Ctrl_ExcpPC       (Ctrl_ExcpPC),
    .EX_BranchFlag     (EX_BranchFlag),
    .EX_BranchPC       (EX_BranchPC),
    .BP_BranchFlag     (BP_BranchFlag),
    .BranchPredictor_PC(BranchPredictor_PC),
    .Stall             (Stall),
    .ic_req_valid      (ic_req_valid),
    .ic_req_ready      (ic_req_ready),
    .ic_req_addr       (ic_req_addr),
    .ic_resp_valid     (ic_resp_valid),
    .ic_resp_data      (ic_resp_data),
    .inst_valid        (inst_valid),
    .inst              (inst),
    .inst_pc           (inst_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instOf(input logic [31:0] a);
    return {a[15:0], 16'h0013} ^ 32'h5A5A_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic resp, input logic stall, input int cycles);
    ic_req_ready  = ready;
    resp_en       = resp;
    Stall         = stall;
    Ctrl_ExcpFlag = 1'b0;
    EX_BranchFlag = 1'b0;
    BP_BranchFlag = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyRedirect(input logic c, input logic e, input logic b,
                               input logic [31:0] cpc, input logic [31:0] epc, input logic [31:0] bpc,
                               input logic ready, input logic resp);
    Ctrl_ExcpFlag      = c;
    EX_BranchFlag      = e;
    BP_BranchFlag      = b;
    Ctrl_ExcpPC        = cpc;
    EX_BranchPC        = epc;
    BranchPredictor_PC = bpc;
    ic_req_ready       = ready;
    resp_en            = resp;
    Stall              = 1'b0;
    @(posedge clk);
    #1;
    Ctrl_ExcpFlag = 1'b0;
    EX_BranchFlag = 1'b0;
    BP_BranchFlag = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    ic_req_ready = 1'b0;
    resp_en      = 1'b1;
    Stall        = 1'b0;
    while ((pend_q.size() != 0 || exp_q.size() != 0) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (pend_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: pending=%0d buffered=%0d after %0d cycles, expected both 0",
               pend_q.size(), exp_q.size(), n);
    end
  endtask

  // ICache model: answers the oldest request one cycle after it fires, when enabled.
  initial begin
    req_t r;
    ic_resp_valid = 1'b0;
    ic_resp_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        ic_resp_valid = 1'b0;
        resp_real     = 1'b0;
      end else if (resp_en && pend_q.size() != 0) begin
        r             = pend_q.pop_front();
        ic_resp_valid = 1'b1;
        ic_resp_data  = instOf(r.addr);
        resp_addr     = r.addr;
        resp_epoch    = r.epoch;
        resp_real     = 1'b1;
      end else if (spurious) begin
        ic_resp_valid = 1'b1;
        ic_resp_data  = 32'hDEAD_BEEF;
        resp_real     = 1'b0;
      end else begin
        ic_resp_valid = 1'b0;
        resp_real     = 1'b0;
      end
    end
  end

  // Monitor: compares outputs each cycle, then advances the expectation model.
  initial begin
    logic        redir;
    logic [31:0] tgt;
    logic        exp_rv;
    int          outm;
    exp_t        e;
    req_t        r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        redir = Ctrl_ExcpFlag | EX_BranchFlag | BP_BranchFlag;
        tgt   = Ctrl_ExcpFlag ? Ctrl_ExcpPC : (EX_BranchFlag ? EX_BranchPC : BranchPredictor_PC);
        outm  = pend_q.size() + ((ic_resp_valid && resp_real) ? 1 : 0);
        exp_rv = !redir && (outm + exp_q.size() < DEPTH);
        checkOutput("ic_req_valid", 32'(ic_req_valid), 32'(exp_rv));
        if (ic_req_valid)
          checkOutput("ic_req_addr", ic_req_addr, exp_fetch_pc);
        checkOutput("inst_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
        if (inst_valid && exp_q.size() != 0) begin
          checkOutput("inst_pc", inst_pc, exp_q[0].pc);
          checkOutput("inst", inst, exp_q[0].data);
          if (!Stall && !redir) begin
            e = exp_q.pop_front();
            pop_log.push_back(inst_pc);
          end
        end
        if (ic_resp_valid && resp_real && !redir && resp_epoch == epoch) begin
          e.pc   = resp_addr;
          e.data = instOf(resp_addr);
          exp_q.push_back(e);
        end
        if (ic_req_valid && ic_req_ready && !redir) begin
          req_log.push_back(ic_req_addr);
          r.addr  = ic_req_addr;
          r.epoch = epoch;
          pend_q.push_back(r);
          exp_fetch_pc = exp_fetch_pc + 32'd4;
        end
        if (redir) begin
          exp_q.delete();
          epoch++;
          exp_fetch_pc = tgt;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkOutput("reset ic_req_valid", 32'(ic_req_valid), 32'd0);
    checkOutput("reset ic_req_addr", ic_req_addr, START);
    checkOutput("reset inst_valid", 32'(inst_valid), 32'd0);
    checkOutput("reset inst", inst, 32'd0);
    checkOutput("reset inst_pc", inst_pc, 32'd0);
    rst_n = 1'b1;

    // Streaming fetch of four instructions
    applyStimulus(1'b1, 1'b1, 1'b0, 4);
    drain();
    checkOutput("t1 req0", req_log[0], 32'h8000_0000);
    checkOutput("t1 req3", req_log[3], 32'h8000_000C);
    checkOutput("t1 pop0", pop_log[0], 32'h8000_0000);
    checkOutput("t1 pop3", pop_log[3], 32'h8000_000C);

    // Stalled IFID fills the buffer and throttles requests
    applyStimulus(1'b1, 1'b1, 1'b1, 8);
    checkOutput("t2 req_valid full", 32'(ic_req_valid), 32'd0);
    checkOutput("t2 inst_valid", 32'(inst_valid), 32'd1);
    checkOutput("t2 head pc", inst_pc, 32'h8000_0010);
    checkOutput("t2 head inst", inst, instOf(32'h8000_0010));
    applyStimulus(1'b1, 1'b1, 1'b0, 2);
    drain();
    checkOutput("t2 req count", 32'(req_log.size()), 32'd9);
    checkOutput("t2 resume req", req_log[8], 32'h8000_0020);
    checkOutput("t2 pop7", pop_log[7], 32'h8000_001C);

    // Branch redirect with three requests in flight
    applyStimulus(1'b1, 1'b0, 1'b0, 3);
    applyRedirect(1'b0, 1'b1, 1'b0, 32'h0, 32'h8000_0100, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 3);
    drain();
    checkOutput("t3 req after branch", req_log[12], 32'h8000_0100);
    checkOutput("t3 first pop", pop_log[9], 32'h8000_0100);
    checkOutput("t3 pop count", 32'(pop_log.size()), 32'd12);

    // Simultaneous redirects: exception wins
    applyRedirect(1'b1, 1'b1, 1'b1, 32'h8000_0200, 32'h8000_0300, 32'h8000_0400, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    drain();
    checkOutput("t4 priority req", req_log[15], 32'h8000_0200);
    checkOutput("t4 priority pop", pop_log[12], 32'h8000_0200);

    // Redirect coincident with a response, two outstanding
    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    applyRedirect(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h8000_0500, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    drain();
    checkOutput("t5 req after bp", req_log[18], 32'h8000_0500);
    checkOutput("t5 first pop", pop_log[13], 32'h8000_0500);
    checkOutput("t5 pop count", 32'(pop_log.size()), 32'd14);

    // Asynchronous reset mid-stream with one outstanding and three buffered
    applyStimulus(1'b1, 1'b1, 1'b1, 4);
    checkOutput("t6 pre inst_valid", 32'(inst_valid), 32'd1);
    checkOutput("t6 pre head pc", inst_pc, 32'h8000_0504);
    checkOutput("t6 pre req_valid", 32'(ic_req_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("t6 rst ic_req_valid", 32'(ic_req_valid), 32'd0);
    checkOutput("t6 rst ic_req_addr", ic_req_addr, START);
    checkOutput("t6 rst inst_valid", 32'(inst_valid), 32'd0);
    checkOutput("t6 rst inst", inst, 32'd0);
    checkOutput("t6 rst inst_pc", inst_pc, 32'd0);
    pend_q.delete();
    exp_q.delete();
    epoch++;
    exp_fetch_pc = START;
    ic_req_ready = 1'b0;
    Stall        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 2);
    drain();
    checkOutput("t6 first req", req_log[23], 32'h8000_0000);
    checkOutput("t6 first pop", pop_log[14], 32'h8000_0000);
    checkOutput("t6 second pop", pop_log[15], 32'h8000_0004);

    // Stray response with nothing outstanding is ignored
    spurious = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    spurious = 1'b0;
    checkOutput("t7 stray inst_valid", 32'(inst_valid), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    drain();
    checkOutput("t7 req", req_log[25], 32'h8000_0008);
    checkOutput("t7 pop", pop_log[16], 32'h8000_0008);
    checkOutput("t7 pop count", 32'(pop_log.size()), 32'd17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
